// File: rtl/shared_mem_pkg.sv
// Address map, STATUS layout and FSM encoding shared by the shared-memory slave and its mailbox.
package shared_mem_pkg;

  localparam logic [19:0] MSG_ADDR    = 20'h01000;
  localparam logic [19:0] STATUS_ADDR = 20'h01004;
  localparam logic [31:0] ERR_DATA    = 32'hDEADBEEF;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {StIdle, StRd1, StRd2} state_e;
  typedef enum logic [1:0] {RegRam, RegMsg, RegStatus, RegErr} region_e;

endpackage

// File: rtl/shared_mem_slave_if.sv
// Avalon-MM slave port s0 of the shared-memory bridge (single-beat, fixed 2-cycle read latency).
interface shared_mem_slave_if;
  logic [19:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        burstcount;
  logic        debugaccess;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable, burstcount, debugaccess,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount, debugaccess,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/shmem_mbox_fifo.sv
// Mailbox FIFO: drops a push only when full and not popped in the same cycle.
module shmem_mbox_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [31:0]                i_data,
  output logic [31:0]                o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_do_push && !w_do_pop) r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/shared_mem_slave.sv
// Shared-memory slave: byte-enabled RAM, optional mailbox FIFO (SHARED_MEM_MBOX_EN), error region.
module shared_mem_slave
  import shared_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned MBOX_DEPTH = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  shared_mem_slave_if.slave   s0,
  output logic [31:0]         mbox_data,
  output logic                mbox_valid,
  input  logic                mbox_ready,
  output logic                mbox_irq,
  output logic [7:0]          err_count
);
  localparam int unsigned AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned MB_CW = $clog2(MBOX_DEPTH) + 1;

  logic [31:0]      r_mem [MEM_WORDS];
  logic [31:0]      r_ram_rdata;
  state_e           r_state;
  logic             r_waitreq;
  logic             r_rdv;
  logic [31:0]      r_readdata;
  region_e          r_rd_region;
  logic [31:0]      r_rd_aux;
  logic [7:0]       r_err_count;

  logic [17:0]      w_word;
  logic [AW-1:0]    w_ram_idx;
  region_e          w_region;
  logic             w_accept;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_aux;
  logic [MB_CW-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_overflow;
  logic             w_unused;

  assign w_word    = s0.address[19:2];
  assign w_ram_idx = w_word[AW-1:0];
  // Gated with reset so a request during reset leaves RAM untouched.
  assign w_accept  = (s0.read | s0.write) & ~r_waitreq & ~reset_reset;
  assign w_wr_acc  = w_accept & s0.write;
  assign w_rd_acc  = w_accept & s0.read & ~s0.write;

  always_comb begin
    w_region = RegErr;
    if (w_word < 18'(MEM_WORDS)) w_region = RegRam;
`ifdef SHARED_MEM_MBOX_EN
    else if (w_word == MSG_ADDR[19:2]) w_region = RegMsg;
    else if (w_word == STATUS_ADDR[19:2]) w_region = RegStatus;
`endif
  end

  always_comb begin
    w_status                           = '0;
    w_status[STAT_EMPTY_BIT]           = w_empty;
    w_status[STAT_FULL_BIT]            = w_full;
    w_status[STAT_OVF_BIT]             = w_overflow;
    w_status[STAT_COUNT_LSB +: 8]      = 8'(w_count);
  end

  always_comb begin
    case (w_region)
      RegStatus: w_rd_aux = w_status;
      RegErr:    w_rd_aux = ERR_DATA;
      default:   w_rd_aux = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (w_wr_acc && w_region == RegRam) begin
      for (int b = 0; b < 4; b++) begin
        if (s0.byteenable[b]) r_mem[w_ram_idx][8*b +: 8] <= s0.writedata[8*b +: 8];
      end
    end
    if (w_rd_acc) r_ram_rdata <= r_mem[w_ram_idx];
  end

  // Non-RAM read data is snapshotted at accept so it matches the state the master addressed.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state     <= StIdle;
      r_waitreq   <= 1'b0;
      r_rdv       <= 1'b0;
      r_readdata  <= '0;
      r_rd_region <= RegRam;
      r_rd_aux    <= '0;
      r_err_count <= '0;
    end else begin
      r_rdv      <= 1'b0;
      r_readdata <= '0;
      if (w_accept && w_region == RegErr && r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
      case (r_state)
        StIdle: begin
          if (w_rd_acc) begin
            r_state     <= StRd1;
            r_waitreq   <= 1'b1;
            r_rd_region <= w_region;
            r_rd_aux    <= w_rd_aux;
          end
        end
        StRd1: begin
          r_state    <= StRd2;
          r_rdv      <= 1'b1;
          r_readdata <= (r_rd_region == RegRam) ? r_ram_rdata : r_rd_aux;
        end
        StRd2: begin
          r_state   <= StIdle;
          r_waitreq <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s0.waitrequest   = r_waitreq;
  assign s0.readdatavalid = r_rdv;
  assign s0.readdata      = r_readdata;
  assign err_count        = r_err_count;

`ifdef SHARED_MEM_MBOX_EN
  logic        r_overflow;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_head;

  assign w_push = w_wr_acc & (w_region == RegMsg);
  assign w_pop  = mbox_ready & ~w_empty;

  shmem_mbox_fifo #(
    .DEPTH (MBOX_DEPTH)
  ) u_fifo (
    .i_clk   (clk_clk),
    .i_rst   (reset_reset),
    .i_push  (w_push),
    .i_pop   (mbox_ready),
    .i_data  (s0.writedata),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_wr_acc && w_region == RegStatus && s0.writedata[STAT_OVF_BIT]) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_overflow = r_overflow;
  assign mbox_data  = w_head;
  assign mbox_valid = ~w_empty;
  assign mbox_irq   = ~w_empty;
  assign w_unused   = ^{s0.address[1:0], s0.burstcount, s0.debugaccess};
`else
  assign w_count    = '0;
  assign w_full     = 1'b0;
  assign w_empty    = 1'b1;
  assign w_overflow = 1'b0;
  assign mbox_data  = '0;
  assign mbox_valid = 1'b0;
  assign mbox_irq   = 1'b0;
  assign w_unused   = ^{s0.address[1:0], s0.burstcount, s0.debugaccess, mbox_ready};
`endif

endmodule

// File: tb/tb_shared_mem_slave.sv
// Randomized bench for shared_mem_slave against a transaction-level model, plus pinned directed cases.
module tb_shared_mem_slave;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned DEPTH     = 4;
`ifdef SHARED_MEM_MBOX_EN
  localparam bit MBOX_EN = 1'b1;
`else
  localparam bit MBOX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mbox_ready;
  logic [31:0] mbox_data;
  logic        mbox_valid;
  logic        mbox_irq;
  logic [7:0]  err_count;

  shared_mem_slave_if s0_if ();

  shared_mem_slave #(
    .MEM_WORDS  (MEM_WORDS),
    .MBOX_DEPTH (DEPTH)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .s0          (s0_if),
    .mbox_data   (mbox_data),
    .mbox_valid  (mbox_valid),
    .mbox_ready  (mbox_ready),
    .mbox_irq    (mbox_irq),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory words, mailbox queue, sticky overflow, error count, one pending read.
  logic [31:0] m_mem [MEM_WORDS];
  logic [31:0] m_q [$];
  bit          m_ovf;
  int          m_err;
  bit          m_pend;
  int          m_age;
  logic [31:0] m_rdata;
  bit          chk_en = 1'b0;

  function automatic int region(input logic [19:0] a);
    int unsigned w;
    w = 32'(a) >> 2;
    if (w < MEM_WORDS) return 0;
    if (MBOX_EN && w == 32'h400) return 1;
    if (MBOX_EN && w == 32'h401) return 2;
    return 3;
  endfunction

  task automatic model_edge(input bit r, input bit rd, input bit wr, input logic [19:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input bit rdy);
    bit          acc;
    bit          do_pop;
    int          rg;
    int unsigned w;
    logic [31:0] stat;
    if (r) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_err  = 0;
      m_pend = 1'b0;
      return;
    end
    acc    = (rd || wr) && !m_pend;
    do_pop = MBOX_EN && rdy && (m_q.size() > 0);
    stat   = {16'h0, 8'(m_q.size()), 5'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    rg     = region(a);
    w      = 32'(a) >> 2;
    if (m_pend) begin
      if (m_age == 2) m_pend = 1'b0;
      else m_age++;
    end
    if (do_pop) void'(m_q.pop_front());
    if (acc && rg == 3 && m_err < 255) m_err++;
    if (acc && wr) begin
      if (rg == 0) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_mem[w][8*b +: 8] = wd[8*b +: 8];
      end else if (rg == 1) begin
        if (m_q.size() < DEPTH) m_q.push_back(wd);
        else m_ovf = 1'b1;
      end else if (rg == 2) begin
        if (wd[2]) m_ovf = 1'b0;
      end
    end else if (acc && rd) begin
      m_pend  = 1'b1;
      m_age   = 1;
      m_rdata = (rg == 0) ? m_mem[w] : (rg == 2) ? stat : (rg == 3) ? 32'hDEADBEEF : 32'h0;
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("waitrequest", 32'(s0_if.waitrequest), 32'(m_pend));
      chk("readdatavalid", 32'(s0_if.readdatavalid), 32'(m_pend && m_age == 2));
      chk("readdata", s0_if.readdata, (m_pend && m_age == 2) ? m_rdata : 32'h0);
      chk("mbox_valid", 32'(mbox_valid), 32'(m_q.size() > 0));
      chk("mbox_irq", 32'(mbox_irq), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("mbox_data", mbox_data, m_q[0]);
      chk("err_count", 32'(err_count), 32'(m_err));
    end
  end

  logic        obs_wait, obs_rdv, obs_valid, obs_irq;
  logic [31:0] obs_rdata, obs_mdata;
  logic [7:0]  obs_err;

  task automatic step(input bit r, input bit rd, input bit wr, input logic [19:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input bit rdy);
    rst                  = r;
    s0_if.read           = rd;
    s0_if.write          = wr;
    s0_if.address        = a;
    s0_if.writedata      = wd;
    s0_if.byteenable     = be;
    mbox_ready           = rdy;
    @(negedge clk);
    obs_wait  = s0_if.waitrequest;
    obs_rdv   = s0_if.readdatavalid;
    obs_rdata = s0_if.readdata;
    obs_valid = mbox_valid;
    obs_irq   = mbox_irq;
    obs_mdata = mbox_data;
    obs_err   = err_count;
    @(posedge clk);
    model_edge(r, rd, wr, a, wd, be, rdy);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0, rdy);
  endtask

  task automatic wr_word(input logic [19:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input bit rdy);
    step(1'b0, 1'b0, 1'b1, a, wd, be, rdy);
  endtask

  task automatic do_read(input logic [19:0] a, output logic [31:0] data, output int lat,
                         output int waits);
    data  = 32'h0;
    lat   = -1;
    waits = 0;
    step(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      idle(1'b0);
      if (obs_wait) waits++;
      if (obs_rdv && lat < 0) begin
        lat  = i;
        data = obs_rdata;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] rd_data;
  int          lat, waits, n_rdv;
  logic [31:0] got [$];
  int          sel;
  logic [19:0] ra;

  initial begin
    s0_if.burstcount  = 1'b1;
    s0_if.debugaccess = 1'b0;
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0, 1'b0);
    chk_en = 1'b1;
    idle(1'b0);
    chk("reset waitrequest", 32'(obs_wait), 32'h0);
    chk("reset readdatavalid", 32'(obs_rdv), 32'h0);
    chk("reset mbox_valid", 32'(obs_valid), 32'h0);
    chk("reset err_count", 32'(obs_err), 32'h0);

    for (int i = 0; i < 16; i++) wr_word(20'(i * 4), $urandom, 4'hF, 1'b0);

    // Basic write/read with 2-cycle latency.
    wr_word(20'h00010, 32'h12345678, 4'hF, 1'b0);
    do_read(20'h00010, rd_data, lat, waits);
    chk("ram read data", rd_data, 32'h12345678);
    chk("read latency", 32'(lat), 32'd2);
    chk("waitrequest cycles", 32'(waits), 32'd2);

    // Partial byte enables.
    wr_word(20'h00004, 32'h0, 4'hF, 1'b0);
    wr_word(20'h00004, 32'hAABBCCDD, 4'b0101, 1'b0);
    do_read(20'h00004, rd_data, lat, waits);
    chk("byteenable merge", rd_data, 32'h00BB00DD);

`ifdef SHARED_MEM_MBOX_EN
    for (int i = 1; i <= 5; i++) wr_word(20'h01000, 32'(i), 4'hF, 1'b0);
    do_read(20'h01004, rd_data, lat, waits);
    chk("status after overflow", rd_data, 32'h00000406);
    got.delete();
    for (int i = 0; i < 8 && got.size() < 4; i++) begin
      idle(1'b1);
      if (obs_valid) got.push_back(obs_mdata);
    end
    chk("drain count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) chk("drain data", got[i], 32'(i + 1));
    idle(1'b0);
    chk("irq after drain", 32'(obs_irq), 32'h0);
    do_read(20'h01000, rd_data, lat, waits);
    chk("msg read", rd_data, 32'h0);
    wr_word(20'h01004, 32'h4, 4'hF, 1'b0);
    do_read(20'h01004, rd_data, lat, waits);
    chk("status after clear", rd_data, 32'h00000001);
    for (int i = 0; i < 4; i++) wr_word(20'h01000, 32'(10 + i), 4'hF, 1'b0);
    wr_word(20'h01000, 32'h99, 4'hF, 1'b1);
    do_read(20'h01004, rd_data, lat, waits);
    chk("status push+pop full", rd_data, 32'h00000402);
    for (int i = 0; i < 6; i++) idle(1'b1);
`else
    wr_word(20'h01000, 32'h1, 4'hF, 1'b0);
    idle(1'b0);
    chk("mbox_valid disabled", 32'(obs_valid), 32'h0);
    do_read(20'h01004, rd_data, lat, waits);
    chk("status as error", rd_data, 32'hDEADBEEF);
`endif

    // Error region and saturation.
    step(1'b1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0, 1'b0);
    do_read(20'h80000, rd_data, lat, waits);
    chk("error read data", rd_data, 32'hDEADBEEF);
    chk("err_count one", 32'(obs_err), 32'd1);
    for (int i = 0; i < 300; i++) wr_word(20'h80000 + 20'(i * 4), 32'(i), 4'hF, 1'b0);
    idle(1'b0);
    chk("err_count saturated", 32'(obs_err), 32'd255);

    // Reset during RD1 abandons the read; RAM survives reset.
    step(1'b0, 1'b1, 1'b0, 20'h00010, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0, 1'b0);
    chk("waitrequest in RD1", 32'(obs_wait), 32'h1);
    n_rdv = 0;
    idle(1'b0);
    chk("waitrequest after reset", 32'(obs_wait), 32'h0);
    if (obs_rdv) n_rdv++;
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      if (obs_rdv) n_rdv++;
    end
    chk("no readdatavalid after reset", 32'(n_rdv), 32'h0);
    do_read(20'h00010, rd_data, lat, waits);
    chk("ram kept over reset", rd_data, 32'h12345678);

    // Randomized traffic over RAM, mailbox, status and error addresses.
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) ra = 20'($urandom_range(0, 15) * 4);
      else if (sel == 6) ra = 20'h01000;
      else if (sel == 7) ra = 20'h01004;
      else if (sel == 8) ra = 20'h80000;
      else ra = 20'h02000;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           ra, $urandom, 4'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
